// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Entry layouts for the in-flight tag FIFO and the fetch buffer.
package if_fetch_ctrl_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;
    localparam int unsigned EPOCH_W      = 1;

    typedef struct packed {
        logic [EPOCH_W-1:0] epoch;
        logic [31:0]        pc;
    } tag_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with registered storage, flush, and occupancy count.
// Push is accepted when full only if a pop frees a slot in the same cycle.
module if_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage PC owner: issues imem requests under a credit limit, tags them
// with an epoch so pre-redirect responses are dropped, and buffers results for ID.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        ex_is_jump,
    input  logic [31:0] ex_npc,
    input  logic        id_stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        flush_id
);

    localparam int unsigned    CNT_W      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_MAX = BUF_DEPTH[CNT_W:0];

    logic [31:0]        pc;
    logic [EPOCH_W-1:0] epoch;

    tag_t             tag_in;
    tag_t             tag_head;
    fetch_t           buf_in;
    fetch_t           buf_head;
    logic             tag_full, tag_empty;
    logic             buf_full, buf_empty;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W:0]   credit_used;
    logic             can_issue;
    logic             accept;
    logic             resp_pop;
    logic             resp_keep;
    logic             id_pop;

    // Buffered entries hold credit too, so a stalled ID throttles issue and nothing overflows.
    assign credit_used    = {1'b0, inflight} + {1'b0, buf_count};
    assign can_issue      = (credit_used < CREDIT_MAX) & ~tag_full & ~buf_full;
    assign imem_req_valid = can_issue & ~ex_is_jump & ~cpu_rst;
    assign imem_addr      = pc;
    assign accept         = imem_req_valid & imem_req_ready;

    // A response landing in a redirect cycle still carries the pre-flip epoch.
    assign resp_pop  = imem_resp_valid & ~tag_empty;
    assign resp_keep = resp_pop & (tag_head.epoch == epoch) & ~ex_is_jump;

    assign tag_in = '{epoch: epoch, pc: pc};
    assign buf_in = '{pc: tag_head.pc, inst: imem_resp_data};

    assign id_valid = ~buf_empty;
    assign id_pop   = id_valid & ~id_stall;
    assign id_inst  = id_valid ? buf_head.inst : INST_NOP;
    assign id_pc    = buf_head.pc;
    assign id_pc4   = id_pc + 32'd4;
    assign flush_id = ex_is_jump;

    if_fifo #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (BUF_DEPTH)
    ) u_tag_fifo (
        .clk   (cpu_clk),
        .rst   (cpu_rst),
        .flush (1'b0),
        .push  (accept),
        .pop   (resp_pop),
        .wdata (tag_in),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (inflight)
    );

    if_fifo #(
        .WIDTH ($bits(fetch_t)),
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk   (cpu_clk),
        .rst   (cpu_rst),
        .flush (ex_is_jump),
        .push  (resp_keep),
        .pop   (id_pop),
        .wdata (buf_in),
        .rdata (buf_head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            pc    <= RESET_PC;
            epoch <= '0;
        end else if (ex_is_jump) begin
            pc    <= word_align(ex_npc);
            epoch <= ~epoch;
        end else if (accept) begin
            pc <= pc + 32'd4;
        end
    end

endmodule
